sha3_pad_packer: RTL
====================

# sha3_pad_packer

Downstream neighbour of the AXI-Stream receiver in the SHA3 datapath. Accepts the receiver's 16-bit message words with last/byte-valid markers, packs them little-endian into a RATE-bit Keccak block and applies SHA3 padding (domain byte 0x06, final bit 0x80). Emits complete blocks over a valid/ready handshake to the Keccak permutation core, including the extra padding-only block when a message ends on a block boundary.

## Interface
- RATE_BITS, 1088, block width in bits (SHA3-256). Must be a multiple of 16.
- WORDS (localparam), RATE_BITS/16, 16-bit words per block (68 by default).
- ACLK  in  1  clock, all logic on rising edge
- ARESETn  in  1  synchronous, active-low reset
- s_data  in  16  message word; [7:0] is the earlier byte
- s_keep  in  2  byte-valid, sampled only with s_last: 2'b00 none, 2'b01 low byte, 2'b11 both; 2'b10 treated as 2'b11
- s_valid  in  1  word valid
- s_last  in  1  final word of message
- s_ready  out  1  word accepted when s_valid && s_ready
- m_block  out  RATE_BITS  packed block; byte k at bits [8k+7:8k]
- m_valid  out  1  block valid
- m_ready  in  1  Keccak core accepts block
- m_last  out  1  block is the final (padded) block of the message
- busy  out  1  partial block held, or block pending output

## Operation
- States: FILL (s_ready=1, m_valid=0), OUT (s_ready=0, m_valid=1). Flag pend_pad marks an owed padding-only block.
- Word counter wcnt 0..WORDS-1; accepted word written to m_block[16*wcnt+15:16*wcnt], wcnt increments.
- Non-last word at wcnt==WORDS-1: go OUT, m_last=0, wcnt wraps to 0.
- Last word, byte count n (0,1,2) at word wcnt: data bytes written, byte p=2*wcnt+n gets 0x06 if p<RATE_BITS/8, byte RATE_BITS/8-1 ORed with 0x80 (so p==last byte yields 0x86); go OUT, m_last=1.
- Last word with n=2 at wcnt==WORDS-1 (block exactly full): go OUT with m_last=0, set pend_pad.
- OUT, m_valid && m_ready: block cleared to zero, wcnt=0. If pend_pad: load byte0=0x06, last byte=0x80, m_last=1, clear pend_pad, stay OUT. Else go FILL, m_last=0.
- Empty message: single beat s_last=1, s_keep=00 at wcnt=0 -> padding-only block.
- Bytes beyond the message inside a block are zero.
- busy = (wcnt!=0) || state==OUT.

## Timing
- Reset (ARESETn low at a rising edge): state FILL, wcnt=0, pend_pad=0, m_block=0, m_valid=0, m_last=0, busy=0; s_ready forced 0 while ARESETn low, 1 from first edge with ARESETn high.
- Reset mid-block or mid-OUT discards all held data; no block emitted.
- Latency: m_valid rises the cycle after the edge that accepts the completing word.
- m_block/m_last stable while m_valid && !m_ready; m_valid never drops without handshake.
- Padding-only block: m_valid stays high, new contents visible the cycle after the first block's handshake.
- First word of next block accepted the cycle after the final handshake (one-cycle bubble per block; s_ready low in OUT).
- s_valid gaps any length; no word lost or duplicated.

## Test plan
- Empty message: one beat s_keep=00, s_last=1 -> one block, m_block[7:0]=0x06, m_block[1087:1080]=0x80, rest 0, m_last=1.
- "abc": s_data=0x6261 keep 11, then 0x0063 keep 01 last -> m_block[31:0]=0x06636261, byte 135=0x80, m_last=1.
- 135-byte message (67 full words + 1 word keep 01 last) -> single block, byte 135=0x86, m_last=1.
- 136-byte message (68 full words, last keep 11) -> block 1 data only, m_last=0; block 2 byte0=0x06, byte135=0x80, m_last=1.
- Backpressure: m_ready low 5 cycles with s_valid high -> m_block stable, s_ready=0, no beat accepted; random s_valid gaps on a 200-byte message produce correct two blocks.
- Reset after 10 accepted words -> no m_valid, busy=0; subsequent "abc" yields the block of scenario 2.

Source files
------------

// File: rtl/sha3_pad_packer_if.sv
// Word stream in from the AXI-Stream receiver and block stream out to the Keccak core.
// master = environment side (word source + block sink); slave = the packer.
interface sha3_pad_packer_if #(
    parameter int RATE_BITS = 1088
);
    logic [15:0]          s_data;
    logic [1:0]           s_keep;
    logic                 s_valid;
    logic                 s_last;
    logic                 s_ready;
    logic [RATE_BITS-1:0] m_block;
    logic                 m_valid;
    logic                 m_ready;
    logic                 m_last;

    modport master (
        output s_data, s_keep, s_valid, s_last, m_ready,
        input  s_ready, m_block, m_valid, m_last
    );

    modport slave (
        input  s_data, s_keep, s_valid, s_last, m_ready,
        output s_ready, m_block, m_valid, m_last
    );
endinterface

// File: rtl/sha3_pad_packer.sv
// Packs 16-bit message words little-endian into RATE-bit Keccak blocks and applies
// SHA3 padding (0x06 domain byte, 0x80 final bit), including the extra padding-only block.
module sha3_pad_packer #(
    parameter int RATE_BITS = 1088
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    sha3_pad_packer_if.slave  bus,
    output logic              busy
);
    localparam int WORDS = RATE_BITS / 16;
    localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [WCW-1:0] WLAST = WCW'(WORDS - 1);

    typedef enum logic {
        FILL = 1'b0,
        OUT  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [WCW-1:0]       wcnt_q, wcnt_d;
    logic                 pend_q, pend_d;
    logic                 last_q, last_d;
    logic [RATE_BITS-1:0] block_q, block_d;

    logic       accept;
    logic [1:0] nbytes;
    int         pad_idx;

    assign bus.s_ready = ARESETn && (state_q == FILL);
    assign accept      = bus.s_valid && bus.s_ready;
    assign bus.m_valid = (state_q == OUT);
    assign bus.m_block = block_q;
    assign bus.m_last  = last_q;
    assign busy        = (wcnt_q != '0) || (state_q == OUT);

    // Keep 2'b10 counts as a full word.
    assign nbytes = bus.s_keep[1] ? 2'd2 : (bus.s_keep[0] ? 2'd1 : 2'd0);

    // NOTE: every signal is given its hold value first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        pend_d  = pend_q;
        last_d  = last_q;
        block_d = block_q;
        pad_idx = 2 * int'(wcnt_q) + int'(nbytes);

        case (state_q)
            FILL: begin
                if (accept) begin
                    if (!bus.s_last) begin
                        block_d[16*wcnt_q +: 16] = bus.s_data;
                        if (wcnt_q == WLAST) begin
                            state_d = OUT;
                            wcnt_d  = '0;
                            last_d  = 1'b0;
                        end else begin
                            wcnt_d = wcnt_q + WCW'(1);
                        end
                    end else begin
                        if (nbytes != 2'd0) block_d[16*wcnt_q +: 8]     = bus.s_data[7:0];
                        if (nbytes == 2'd2) block_d[16*wcnt_q + 8 +: 8] = bus.s_data[15:8];
                        state_d = OUT;
                        wcnt_d  = '0;
                        if (nbytes == 2'd2 && wcnt_q == WLAST) begin
                            // Message filled the block exactly: padding goes in a block of its own.
                            last_d = 1'b0;
                            pend_d = 1'b1;
                        end else begin
                            block_d[8*pad_idx +: 8]     = 8'h06;
                            block_d[RATE_BITS-1 -: 8]   = block_d[RATE_BITS-1 -: 8] | 8'h80;
                            last_d = 1'b1;
                        end
                    end
                end
            end
            OUT: begin
                if (bus.m_ready) begin
                    block_d = '0;
                    wcnt_d  = '0;
                    if (pend_q) begin
                        block_d[7:0]              = 8'h06;
                        block_d[RATE_BITS-1 -: 8] = 8'h80;
                        last_d = 1'b1;
                        pend_d = 1'b0;
                    end else begin
                        state_d = FILL;
                        last_d  = 1'b0;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    // NOTE: the block register is reset too, since untouched bytes of a block must read as zero.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= FILL;
            wcnt_q  <= '0;
            pend_q  <= 1'b0;
            last_q  <= 1'b0;
            block_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so all state updates together at the edge.
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            block_q <= block_d;
        end
    end
endmodule
